// File: rtl/serializer_pkg.sv
// Shared types and elaboration helpers for the parallel-to-serial converter.
package serializer_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } ser_state_t;

   // Counter width for a range of 'value' entries, never narrower than one bit.
   function automatic int clog2_min1(input int value);
      int r;
      r = $clog2(value);
      return (r < 1) ? 1 : r;
   endfunction

   // A frame needs at least two bits per word and two words to be meaningful.
   function automatic bit params_legal(input int word_w, input int num_words);
      return (word_w >= 2) && (num_words >= 2);
   endfunction

endpackage

// File: rtl/ser_index_counter.sv
// Wrap counter: counts 0..MAX with enable and synchronous clear; wrap pulses
// combinationally in the enabled cycle that returns the count to zero.
module ser_index_counter #(
   parameter int WIDTH = 3,
   parameter int MAX   = 7
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             clear,
   input  logic             enable,
   output logic [WIDTH-1:0] count,
   output logic             wrap
);

   localparam logic [WIDTH-1:0] LAST = WIDTH'(MAX);

   assign wrap = enable && !clear && (count == LAST);

   // Count register; clear wins over enable so an abort or fresh load restarts at 0.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         if (count == LAST) begin
            count <= '0;
         end else begin
            count <= count + 1'b1;
         end
      end
   end

endmodule

// File: rtl/param_serializer.sv
// Parallel-to-serial converter: snapshots a NUM_WORDS x WORD_W frame on a
// valid/ready load, then shifts it out one bit per clock with HOLD/ABORT.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | LOAD_READY high, waiting for LOAD_VALID to snapshot PAR_IN
//   ST_SHIFT | one buffer bit per unstalled clock until the frame ends
module param_serializer
   import serializer_pkg::*;
#(
   parameter int WORD_W    = 32,
   parameter int NUM_WORDS = 8,
   parameter bit MSB_FIRST = 1'b0
) (
   input  logic                                 CLK,
   input  logic                                 RESET,
   input  logic                                 LOAD_VALID,
   output logic                                 LOAD_READY,
   input  logic [NUM_WORDS*WORD_W-1:0]          PAR_IN,
   input  logic                                 HOLD,
   input  logic                                 ABORT,
   output logic                                 SERIAL_OUT,
   output logic                                 SERIAL_VALID,
   output logic                                 WORD_DONE,
   output logic                                 FRAME_DONE,
   output logic [clog2_min1(WORD_W)-1:0]        BIT_COUNT,
   output logic [clog2_min1(NUM_WORDS)-1:0]     WORD_COUNT
);

   localparam int BW = clog2_min1(WORD_W);
   localparam int WW = clog2_min1(NUM_WORDS);
   localparam logic [BW-1:0] BIT_MAX = BW'(WORD_W - 1);

   if (!params_legal(WORD_W, NUM_WORDS)) begin : g_bad_params
      $error("param_serializer: WORD_W and NUM_WORDS must both be >= 2");
   end

   ser_state_t        state_q;
   ser_state_t        state_d;
   logic              load_fire;
   logic              shift_en;
   logic              cnt_clear;
   logic              bit_wrap;
   logic              word_wrap;
   logic [WORD_W-1:0] buf_q [NUM_WORDS];
   logic [WORD_W-1:0] cur_word;
   logic [BW-1:0]     bit_sel;
   logic              next_bit;

   assign LOAD_READY = (state_q == ST_IDLE);
   assign load_fire  = (state_q == ST_IDLE) && LOAD_VALID && !ABORT;
   assign shift_en   = (state_q == ST_SHIFT) && !HOLD && !ABORT;
   assign cnt_clear  = ABORT || load_fire;

   ser_index_counter #(
      .WIDTH (BW),
      .MAX   (WORD_W - 1)
   ) u_bit_cnt (
      .CLK    (CLK),
      .RESET  (RESET),
      .clear  (cnt_clear),
      .enable (shift_en),
      .count  (BIT_COUNT),
      .wrap   (bit_wrap)
   );

   // Word counter only advances on the bit counter's wrap, so its own wrap marks the frame end.
   ser_index_counter #(
      .WIDTH (WW),
      .MAX   (NUM_WORDS - 1)
   ) u_word_cnt (
      .CLK    (CLK),
      .RESET  (RESET),
      .clear  (cnt_clear),
      .enable (bit_wrap),
      .count  (WORD_COUNT),
      .wrap   (word_wrap)
   );

   // State register.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: abort beats everything, the frame ends on the word counter's wrap.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (load_fire) begin
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (ABORT || word_wrap) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Shadow buffer: snapshot the whole frame on accept so PAR_IN may change freely afterwards.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         for (int i = 0; i < NUM_WORDS; i++) begin
            buf_q[i] <= '0;
         end
      end else if (load_fire) begin
         for (int i = 0; i < NUM_WORDS; i++) begin
            buf_q[i] <= PAR_IN[i*WORD_W +: WORD_W];
         end
      end
   end

   // Output mux: pick the current word, then the bit in transmission order.
   always_comb begin
      cur_word = buf_q[WORD_COUNT];
      bit_sel  = BIT_COUNT;
      if (MSB_FIRST) begin
         bit_sel = BIT_MAX - BIT_COUNT;
      end
      next_bit = cur_word[bit_sel];
   end

   // Registered serial outputs and done pulses; SERIAL_OUT holds its value through a stall.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         SERIAL_OUT   <= 1'b0;
         SERIAL_VALID <= 1'b0;
         WORD_DONE    <= 1'b0;
         FRAME_DONE   <= 1'b0;
      end else if (ABORT) begin
         SERIAL_OUT   <= 1'b0;
         SERIAL_VALID <= 1'b0;
         WORD_DONE    <= 1'b0;
         FRAME_DONE   <= 1'b0;
      end else if (shift_en) begin
         SERIAL_OUT   <= next_bit;
         SERIAL_VALID <= 1'b1;
         WORD_DONE    <= bit_wrap;
         FRAME_DONE   <= word_wrap;
      end else begin
         SERIAL_VALID <= 1'b0;
         WORD_DONE    <= 1'b0;
         FRAME_DONE   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_param_serializer.sv
// Bench for param_serializer: an LSB-first and an MSB-first instance share
// stimulus; expected bits come from a frame-level bit-position model.
module tb_param_serializer;

   localparam int W  = 8;
   localparam int NW = 4;
   localparam int NB = W * NW;

   logic          CLK = 1'b0;
   logic          RESET = 1'b1;
   logic          LOAD_VALID = 1'b0;
   logic          HOLD = 1'b0;
   logic          ABORT = 1'b0;
   logic [NB-1:0] PAR_IN = '0;

   logic       lr_l, so_l, sv_l, wd_l, fd_l;
   logic [2:0] bc_l;
   logic [1:0] wc_l;
   logic       lr_m, so_m, sv_m, wd_m, fd_m;
   logic [2:0] bc_m;
   logic [1:0] wc_m;

   logic [NB-1:0] frame_q;
   int n_checks = 0;
   int n_fail = 0;

   always #5 CLK = ~CLK;

   param_serializer #(.WORD_W(W), .NUM_WORDS(NW), .MSB_FIRST(1'b0)) dut (
      .CLK(CLK), .RESET(RESET), .LOAD_VALID(LOAD_VALID), .LOAD_READY(lr_l),
      .PAR_IN(PAR_IN), .HOLD(HOLD), .ABORT(ABORT), .SERIAL_OUT(so_l),
      .SERIAL_VALID(sv_l), .WORD_DONE(wd_l), .FRAME_DONE(fd_l),
      .BIT_COUNT(bc_l), .WORD_COUNT(wc_l)
   );

   param_serializer #(.WORD_W(W), .NUM_WORDS(NW), .MSB_FIRST(1'b1)) dut_msb (
      .CLK(CLK), .RESET(RESET), .LOAD_VALID(LOAD_VALID), .LOAD_READY(lr_m),
      .PAR_IN(PAR_IN), .HOLD(HOLD), .ABORT(ABORT), .SERIAL_OUT(so_m),
      .SERIAL_VALID(sv_m), .WORD_DONE(wd_m), .FRAME_DONE(fd_m),
      .BIT_COUNT(bc_m), .WORD_COUNT(wc_m)
   );

   // Bit j of the serial stream: word j/W, position within word by send order.
   function automatic logic exp_bit(input logic [NB-1:0] fr, input int j, input bit msb);
      int wi;
      int bi;
      wi = j / W;
      bi = j % W;
      if (msb) bi = W - 1 - bi;
      return fr[wi*W + bi];
   endfunction

   task automatic test_reset();
      RESET = 1'b1;
      repeat (2) @(negedge CLK);
      n_checks++;
      if ({so_l, sv_l, wd_l, fd_l, bc_l, wc_l} !== 9'b0) begin
         n_fail++;
         $display("FAIL reset_outputs got %b required 0", {so_l, sv_l, wd_l, fd_l, bc_l, wc_l});
      end
      n_checks++;
      if ({so_m, sv_m, wd_m, fd_m} !== 4'b0) begin
         n_fail++;
         $display("FAIL reset_outputs_msb got %b required 0", {so_m, sv_m, wd_m, fd_m});
      end
      RESET = 1'b0;
      @(negedge CLK);
      n_checks++;
      if (lr_l !== 1'b1 || lr_m !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_load_ready got %b%b required 11", lr_l, lr_m);
      end
   endtask

   // Loads frame_q and follows it to the end (or to an abort before bit abort_at).
   task automatic run_frame(input int hold_at, input int hold_len, input bit keep_valid,
                            input int abort_at);
      int  j;
      int  held;
      int  cyc;
      bit  h;
      PAR_IN = frame_q;
      LOAD_VALID = 1'b1;
      HOLD = 1'b0;
      ABORT = 1'b0;
      @(negedge CLK);
      n_checks++;
      if (lr_l !== 1'b0 || sv_l !== 1'b0 || sv_m !== 1'b0 || bc_l !== 3'd0 || wc_l !== 2'd0) begin
         n_fail++;
         $display("FAIL accept_state ready=%b valid=%b%b bit=%0d word=%0d required 0 00 0 0",
                  lr_l, sv_l, sv_m, bc_l, wc_l);
      end
      LOAD_VALID = keep_valid;
      PAR_IN = $urandom;
      j = 0;
      held = 0;
      cyc = 0;
      while (j < NB) begin
         if (j == abort_at) begin
            ABORT = 1'b1;
            HOLD = 1'b1;
            LOAD_VALID = 1'b1;
            @(negedge CLK);
            n_checks++;
            if ({so_l, sv_l, wd_l, fd_l, bc_l, wc_l, so_m, sv_m, fd_m} !== 12'b0 || lr_l !== 1'b1) begin
               n_fail++;
               $display("FAIL abort_outputs got %b ready=%b required all 0 ready=1",
                        {so_l, sv_l, wd_l, fd_l, bc_l, wc_l, so_m, sv_m, fd_m}, lr_l);
            end
            ABORT = 1'b0;
            HOLD = 1'b0;
            return;
         end
         h = (j == hold_at) && (held < hold_len);
         HOLD = h;
         @(negedge CLK);
         cyc++;
         PAR_IN = $urandom;
         if (h) begin
            held++;
            n_checks++;
            if (sv_l !== 1'b0 || sv_m !== 1'b0 || wd_l !== 1'b0 || fd_l !== 1'b0 ||
                bc_l !== 3'(j % W)) begin
               n_fail++;
               $display("FAIL hold_freeze j=%0d valid=%b%b wd=%b fd=%b bit=%0d required 00 0 0 %0d",
                        j, sv_l, sv_m, wd_l, fd_l, bc_l, j % W);
            end
            if (j > 0) begin
               n_checks++;
               if (so_l !== exp_bit(frame_q, j - 1, 1'b0) || so_m !== exp_bit(frame_q, j - 1, 1'b1)) begin
                  n_fail++;
                  $display("FAIL hold_keep_out j=%0d got %b%b required %b%b", j, so_l, so_m,
                           exp_bit(frame_q, j - 1, 1'b0), exp_bit(frame_q, j - 1, 1'b1));
               end
            end
         end else begin
            n_checks++;
            if (sv_l !== 1'b1 || sv_m !== 1'b1) begin
               n_fail++;
               $display("FAIL serial_valid j=%0d got %b%b required 11", j, sv_l, sv_m);
            end
            n_checks++;
            if (so_l !== exp_bit(frame_q, j, 1'b0)) begin
               n_fail++;
               $display("FAIL data_lsb j=%0d got %b required %b", j, so_l, exp_bit(frame_q, j, 1'b0));
            end
            n_checks++;
            if (so_m !== exp_bit(frame_q, j, 1'b1)) begin
               n_fail++;
               $display("FAIL data_msb j=%0d got %b required %b", j, so_m, exp_bit(frame_q, j, 1'b1));
            end
            n_checks++;
            if (wd_l !== ((j % W) == W - 1) || fd_l !== (j == NB - 1) || fd_m !== (j == NB - 1)) begin
               n_fail++;
               $display("FAIL done_pulses j=%0d word_done=%b frame_done=%b%b required %b %b",
                        j, wd_l, fd_l, fd_m, (j % W) == W - 1, j == NB - 1);
            end
            n_checks++;
            if (bc_l !== 3'((j + 1) % W) || wc_l !== 2'(((j + 1) / W) % NW)) begin
               n_fail++;
               $display("FAIL counters j=%0d bit=%0d word=%0d required %0d %0d",
                        j, bc_l, wc_l, (j + 1) % W, ((j + 1) / W) % NW);
            end
            if (j == NB - 1) begin
               n_checks++;
               if (lr_l !== 1'b1 || cyc != NB + held) begin
                  n_fail++;
                  $display("FAIL frame_end ready=%b cycles=%0d required 1 %0d", lr_l, cyc, NB + held);
               end
            end
            j++;
         end
      end
      HOLD = 1'b0;
   endtask

   task automatic check_idle_gap(input string name);
      @(negedge CLK);
      n_checks++;
      if (sv_l !== 1'b0 || fd_l !== 1'b0 || lr_l !== 1'b1) begin
         n_fail++;
         $display("FAIL %s valid=%b fd=%b ready=%b required 0 0 1", name, sv_l, fd_l, lr_l);
      end
   endtask

   task automatic test_basic();
      frame_q = 32'h01FF_3CA5;
      run_frame(-1, 0, 1'b0, -1);
      check_idle_gap("basic_idle");
   endtask

   task automatic test_hold();
      frame_q = 32'h01FF_3CA5;
      run_frame(10, 3, 1'b0, -1);
      check_idle_gap("hold_idle");
   endtask

   task automatic test_abort();
      frame_q = 32'h01FF_3CA5;
      run_frame(-1, 0, 1'b0, 20);
      frame_q = $urandom;
      run_frame(-1, 0, 1'b0, -1);
      check_idle_gap("abort_idle");
   endtask

   task automatic test_back_to_back();
      frame_q = $urandom;
      run_frame(-1, 0, 1'b1, -1);
      frame_q = $urandom;
      run_frame(-1, 0, 1'b0, -1);
      check_idle_gap("b2b_idle");
   endtask

   task automatic test_random();
      for (int k = 0; k < 6; k++) begin
         frame_q = $urandom;
         run_frame(int'($urandom_range(0, NB - 1)), int'($urandom_range(0, 4)), 1'b0, -1);
         repeat ($urandom_range(0, 2)) @(negedge CLK);
      end
      check_idle_gap("random_idle");
   endtask

   task automatic test_async_reset();
      frame_q = $urandom;
      PAR_IN = frame_q;
      LOAD_VALID = 1'b1;
      @(negedge CLK);
      LOAD_VALID = 1'b0;
      repeat (12) @(negedge CLK);
      n_checks++;
      if (sv_l !== 1'b1 || bc_l !== 3'd4 || wc_l !== 2'd1) begin
         n_fail++;
         $display("FAIL pre_reset_progress valid=%b bit=%0d word=%0d required 1 4 1", sv_l, bc_l, wc_l);
      end
      #2 RESET = 1'b1;
      #1;
      n_checks++;
      if ({so_l, sv_l, wd_l, fd_l, bc_l, wc_l, so_m, sv_m, fd_m} !== 12'b0) begin
         n_fail++;
         $display("FAIL async_reset_outputs got %b required all 0",
                  {so_l, sv_l, wd_l, fd_l, bc_l, wc_l, so_m, sv_m, fd_m});
      end
      @(negedge CLK);
      RESET = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge CLK);
         n_checks++;
         if (lr_l !== 1'b1 || fd_l !== 1'b0 || sv_l !== 1'b0 || fd_m !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_idle k=%0d ready=%b fd=%b%b valid=%b required 1 00 0",
                     k, lr_l, fd_l, fd_m, sv_l);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_hold();
      test_abort();
      test_back_to_back();
      test_random();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
